// File: rtl/mem_stream_reader_pkg.sv
// Shared types and sizing for the memory stream reader.
package mem_stream_reader_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    // Entries in the latency-absorbing output buffer
    localparam int unsigned BUF_DEPTH = 2;

endpackage

// File: rtl/mem_stream_reader_skid.sv
// Two-entry register buffer that holds words returned by memory until the stream accepts them.
module stream_skid_buffer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] qout,
    output logic             valid,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] tail_r;
    logic [1:0]       count_r;

    // Head always holds the oldest word; a pop shifts the tail forward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_r <= din;
                    end else begin
                        tail_r <= din;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    head_r  <= tail_r;
                    count_r <= count_r - 2'd1;
                end
                2'b11: begin
                    // Pop implies at least one entry, so only occupancy 1 or 2 can reach here
                    if (count_r == 2'd1) begin
                        head_r <= din;
                    end else begin
                        head_r <= tail_r;
                        tail_r <= din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign qout  = head_r;
    assign valid = (count_r != 2'd0);
    assign count = count_r;

endmodule

// File: rtl/mem_stream_reader.sv
// Read-side DMA engine: sequential memory reads streamed out on a valid/ready interface.
module mem_stream_reader
    import mem_stream_reader_pkg::*;
#(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned LOG2_OF_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     arst_n_in,
    input  logic [LOG2_OF_DEPTH-1:0] cmd_addr,
    input  logic [LOG2_OF_DEPTH:0]   cmd_len,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    output logic [LOG2_OF_DEPTH-1:0] mem_read_addr,
    output logic                     mem_read_en,
    input  logic [WIDTH-1:0]         mem_qout,
    output logic [WIDTH-1:0]         qout,
    output logic                     output_valid,
    input  logic                     output_ready,
    output logic                     last,
    output logic                     busy
);

    localparam int unsigned AW = LOG2_OF_DEPTH;
    localparam int unsigned LW = LOG2_OF_DEPTH + 1;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   addr_r;
    logic [LW-1:0]   remaining_r;
    logic [LW-1:0]   out_left_r;
    logic            inflight_r;
    logic [1:0]      buf_count;
    logic            pop_c;
    logic            issue_c;
    logic [2:0]      occ_c;

    assign pop_c = output_valid && output_ready;
    assign last  = output_valid && (out_left_r == LW'(1));
    // Buffer slots already claimed once this cycle's pop is accounted for
    assign occ_c = 3'(buf_count) + 3'(inflight_r) - 3'(pop_c);

    // State register
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; zero-length commands are consumed without leaving IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_valid && (cmd_len != LW'(0))) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                if (pop_c && last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode; a read is only issued when its word is guaranteed a buffer slot
    always_comb begin
        cmd_ready     = 1'b0;
        busy          = 1'b0;
        issue_c       = 1'b0;
        mem_read_en   = 1'b0;
        mem_read_addr = addr_r;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
            end
            READ: begin
                busy        = 1'b1;
                issue_c     = (remaining_r != LW'(0)) && (occ_c < 3'(BUF_DEPTH));
                mem_read_en = issue_c;
            end
            default: begin
            end
        endcase
    end

    // Command registers, issue/output counters and the read-in-flight flag
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            addr_r      <= '0;
            remaining_r <= '0;
            out_left_r  <= '0;
            inflight_r  <= 1'b0;
        end else begin
            inflight_r <= issue_c;
            if (cmd_valid && cmd_ready) begin
                addr_r      <= cmd_addr;
                remaining_r <= cmd_len;
                out_left_r  <= cmd_len;
            end else begin
                if (issue_c) begin
                    addr_r      <= addr_r + AW'(1);
                    remaining_r <= remaining_r - LW'(1);
                end
                if (pop_c) begin
                    out_left_r <= out_left_r - LW'(1);
                end
            end
        end
    end

    // Memory data lands one cycle after the read strobe and is captured unconditionally
    stream_skid_buffer #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk   (clk),
        .rst_n (arst_n_in),
        .push  (inflight_r),
        .din   (mem_qout),
        .pop   (pop_c),
        .qout  (qout),
        .valid (output_valid),
        .count (buf_count)
    );

endmodule

// File: tb/tb_mem_stream_reader.sv
// Scoreboard bench for mem_stream_reader with a one-cycle-latency memory model.
module tb_mem_stream_reader;

    localparam int unsigned W  = 32;
    localparam int unsigned AW = 4;
    localparam int unsigned DEPTH = 16;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    logic          clk = 1'b0;
    logic          arst_n_in = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [AW:0]   cmd_len = '0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] mem_read_addr;
    logic          mem_read_en;
    logic [W-1:0]  mem_qout = '0;
    logic [W-1:0]  qout;
    logic          output_valid;
    logic          output_ready = 1'b1;
    logic          last;
    logic          busy;

    logic [W-1:0]  mem [DEPTH];
    exp_t          exp_q [$];
    int            exp_addr [$];

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   pop_cnt = 0;
    int   last_pop_cyc = -100;
    int   first_hs = 0;
    bit   first_rd = 0;
    bit   first_out = 0;
    bit   stalled = 0;
    logic [W-1:0] stall_q = '0;
    bit   chk_ready_next = 0;
    bit   bp_en = 0;
    logic [5:0] bp_pat = 6'b101001;
    int   bp_idx = 0;

    mem_stream_reader #(
        .WIDTH         (W),
        .LOG2_OF_DEPTH (AW)
    ) u_dut (
        .clk           (clk),
        .arst_n_in     (arst_n_in),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .mem_read_addr (mem_read_addr),
        .mem_read_en   (mem_read_en),
        .mem_qout      (mem_qout),
        .qout          (qout),
        .output_valid  (output_valid),
        .output_ready  (output_ready),
        .last          (last),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory with one-cycle read latency
    always @(posedge clk) begin
        if (mem_read_en) mem_qout <= mem[mem_read_addr];
    end

    // Downstream ready: always high, or a repeating 1,0,0,1,0,1 pattern
    always @(posedge clk) begin
        #1;
        if (bp_en) begin
            output_ready = bp_pat[bp_idx];
            bp_idx = (bp_idx + 1) % 6;
        end else begin
            output_ready = 1'b1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every read strobe and every stream handshake
    always @(negedge clk) begin
        if (!arst_n_in) begin
            stalled = 0;
            chk_ready_next = 0;
        end else begin
            if (chk_ready_next) begin
                check("cmd_ready_after_last", cmd_ready, 1);
                chk_ready_next = 0;
            end
            if (mem_read_en) begin
                if (exp_addr.size() == 0) begin
                    check("unexpected_read", 1, 0);
                end else begin
                    check("read_addr", mem_read_addr, exp_addr.pop_front());
                end
                if (first_rd) begin
                    check("first_read_cycle", cyc, first_hs + 1);
                    first_rd = 0;
                end
            end
            if (stalled) begin
                check("stall_valid", output_valid, 1);
                check("stall_qout", qout, stall_q);
            end
            if (output_valid && first_out) begin
                check("first_out_cycle", cyc, first_hs + 3);
                first_out = 0;
            end
            if (output_valid) check("buf_count_le2", (u_dut.buf_count <= 2), 1);
            if (output_valid && output_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("qout", qout, e.data);
                    check("last", last, e.last);
                    if (e.last) begin
                        check("cmd_ready_low_at_last", cmd_ready, 0);
                        last_pop_cyc = cyc;
                        chk_ready_next = 1;
                    end
                end
                pop_cnt++;
            end
            stalled = output_valid && !output_ready;
            stall_q = qout;
        end
    end

    // Presents a command, waits for acceptance and records the expected reads and words
    task automatic send_cmd(input int a, input int n, output int hs);
        int waited = 0;
        @(posedge clk); #1;
        cmd_addr  = AW'(a);
        cmd_len   = (AW + 1)'(n);
        cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && waited < 300) begin
            waited++;
            @(negedge clk);
        end
        hs = cyc;
        if (!cmd_ready) check("cmd_accept_timeout", 0, 1);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            int ai;
            ai = (a + i) % DEPTH;
            e.data = mem[ai];
            e.last = (i == n - 1);
            exp_addr.push_back(ai);
            exp_q.push_back(e);
        end
        if (n > 0) begin
            first_hs  = hs;
            first_rd  = 1;
            first_out = 1;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        bit done = 0;
        while (!done && n < 300) begin
            @(negedge clk); #1;
            n++;
            done = (exp_q.size() == 0) && (exp_addr.size() == 0) && cmd_ready;
        end
        check({name, "_complete"}, done, 1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_cmd_ready"}, cmd_ready, 1);
        check({name, "_busy"}, busy, 0);
        check({name, "_mem_read_en"}, mem_read_en, 0);
        check({name, "_mem_read_addr"}, mem_read_addr, 0);
        check({name, "_output_valid"}, output_valid, 0);
        check({name, "_last"}, last, 0);
        check({name, "_qout"}, qout, 0);
    endtask

    initial begin
        int hs;
        int hs2;
        int target;
        for (int i = 0; i < DEPTH; i++) mem[i] = W'(i + 100);

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(negedge clk); #2;
        arst_n_in = 1'b1;
        repeat (2) @(negedge clk);

        // Basic read: 103..106, first word three cycles after acceptance
        send_cmd(3, 4, hs);
        wait_idle("basic");
        check("basic_last_cycle", last_pop_cyc, hs + 6);

        // Address wrap: reads 14,15,0,1
        send_cmd(14, 4, hs);
        wait_idle("wrap");

        // Backpressure with a 1,0,0,1,0,1 ready pattern
        bp_en = 1;
        send_cmd(7, 6, hs);
        wait_idle("backpressure");
        bp_en = 0;
        @(negedge clk);

        // Zero length: nothing issued, engine stays idle
        send_cmd(3, 0, hs);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check("zero_len_no_read", mem_read_en, 0);
            check("zero_len_no_valid", output_valid, 0);
            check("zero_len_ready", cmd_ready, 1);
        end

        // Queued command: accepted only the cycle after the running command's last handshake
        send_cmd(0, 2, hs);
        send_cmd(9, 3, hs2);
        check("queued_accept_cycle", hs2, last_pop_cyc + 1);
        wait_idle("queued");

        // Full depth from address 5, ending on mem[4]
        send_cmd(5, 16, hs);
        wait_idle("full_depth");
        check("full_depth_last_cycle", last_pop_cyc, hs + 18);

        // Reset after two of eight words
        target = pop_cnt + 2;
        send_cmd(0, 8, hs);
        for (int i = 0; i < 50 && pop_cnt < target; i++) begin
            @(negedge clk); #1;
        end
        check("mid_reset_two_words", pop_cnt >= target, 1);
        arst_n_in = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        exp_q.delete();
        exp_addr.delete();
        first_rd  = 0;
        first_out = 0;
        repeat (2) @(negedge clk);
        #2;
        arst_n_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            check("post_reset_quiet", output_valid, 0);
        end
        send_cmd(0, 1, hs);
        wait_idle("post_reset_cmd");

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
